// File: rtl/dynamixel_status_parser_if.sv
// Byte-stream input and decoded status-packet outputs of the Dynamixel status parser.
// The byte source drives the master side; the parser is the slave.
interface dynamixel_status_parser_if #(
  parameter int MAX_PARAMS = 4
);
  logic                    rx_valid;
  logic [7:0]              rx_data;
  logic [7:0]              expected_id;
  logic                    pkt_valid;
  logic [7:0]              pkt_id;
  logic [7:0]              pkt_error;
  logic [3:0]              pkt_nparams;
  logic [8*MAX_PARAMS-1:0] pkt_params;
  logic                    chk_err;
  logic                    len_err;
  logic                    id_err;
  logic                    timeout_err;
  logic                    busy;

  modport master (
    output rx_valid, rx_data, expected_id,
    input  pkt_valid, pkt_id, pkt_error, pkt_nparams, pkt_params,
    input  chk_err, len_err, id_err, timeout_err, busy
  );

  modport slave (
    input  rx_valid, rx_data, expected_id,
    output pkt_valid, pkt_id, pkt_error, pkt_nparams, pkt_params,
    output chk_err, len_err, id_err, timeout_err, busy
  );
endinterface

// File: rtl/dynamixel_status_parser.sv
// Protocol 1.0 status-packet parser (FF FF ID LEN ERR P0..Pn-1 CHK).
// Latches good packets and raises one-cycle error pulses; includes an inter-byte timeout.
module dynamixel_status_parser #(
  parameter int MAX_PARAMS     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                     clk,
  input logic                     reset,
  dynamixel_status_parser_if.slave bus
);
  localparam int              TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [7:0]      LEN_MAX  = 8'(MAX_PARAMS + 2);

  typedef enum logic [2:0] {S_IDLE, S_HDR2, S_ID, S_LEN, S_ERR, S_PARAM, S_CHK} state_t;

  state_t                  state, state_n;
  logic [7:0]              sum, id_q, err_q, len_q;
  logic [3:0]              cnt;
  logic [8*MAX_PARAMS-1:0] pbuf;
  logic [TW-1:0]           tmr;
  logic                    clr_pkt, add_sum, st_id, st_len, st_err, st_param;
  logic                    go_pkt, go_chk, go_len, go_id, go_tmo;
  logic                    tmo_hit, id_ok;

  // Fires on the edge where the idle counter would reach TIMEOUT_CYCLES-1; a byte always wins.
  assign tmo_hit   = (state != S_IDLE) && !bus.rx_valid && (tmr == TMO_LAST);
  assign id_ok     = (id_q == bus.expected_id) || (bus.expected_id == 8'hFE);
  assign bus.busy  = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    clr_pkt  = 1'b0;
    add_sum  = 1'b0;
    st_id    = 1'b0;
    st_len   = 1'b0;
    st_err   = 1'b0;
    st_param = 1'b0;
    go_pkt   = 1'b0;
    go_chk   = 1'b0;
    go_len   = 1'b0;
    go_id    = 1'b0;
    go_tmo   = 1'b0;
    if (bus.rx_valid) begin
      case (state)
        S_IDLE: if (bus.rx_data == 8'hFF) state_n = S_HDR2;
        S_HDR2: begin
          if (bus.rx_data == 8'hFF) begin
            state_n = S_ID;
            clr_pkt = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_ID: begin
          if (bus.rx_data == 8'hFF) begin
            clr_pkt = 1'b1;
          end else begin
            st_id   = 1'b1;
            add_sum = 1'b1;
            state_n = S_LEN;
          end
        end
        S_LEN: begin
          if ((bus.rx_data >= 8'd2) && (bus.rx_data <= LEN_MAX)) begin
            st_len  = 1'b1;
            add_sum = 1'b1;
            state_n = S_ERR;
          end else begin
            go_len  = 1'b1;
            state_n = S_IDLE;
          end
        end
        S_ERR: begin
          st_err  = 1'b1;
          add_sum = 1'b1;
          state_n = (len_q == 8'd2) ? S_CHK : S_PARAM;
        end
        S_PARAM: begin
          st_param = 1'b1;
          add_sum  = 1'b1;
          if ({4'd0, cnt} == (len_q - 8'd3)) state_n = S_CHK;
        end
        S_CHK: begin
          // Checksum is judged before the ID so a corrupted ID byte reports as chk_err.
          if (bus.rx_data != ~sum) go_chk = 1'b1;
          else if (!id_ok)         go_id  = 1'b1;
          else                     go_pkt = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      go_tmo  = 1'b1;
      state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum             <= '0;
      id_q            <= '0;
      err_q           <= '0;
      len_q           <= '0;
      cnt             <= '0;
      pbuf            <= '0;
      tmr             <= '0;
      bus.pkt_valid   <= 1'b0;
      bus.chk_err     <= 1'b0;
      bus.len_err     <= 1'b0;
      bus.id_err      <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.pkt_id      <= '0;
      bus.pkt_error   <= '0;
      bus.pkt_nparams <= '0;
      bus.pkt_params  <= '0;
    end else begin
      bus.pkt_valid   <= go_pkt;
      bus.chk_err     <= go_chk;
      bus.len_err     <= go_len;
      bus.id_err      <= go_id;
      bus.timeout_err <= go_tmo;

      if (bus.rx_valid || (state == S_IDLE) || tmo_hit) tmr <= '0;
      else                                              tmr <= tmr + 1'b1;

      // Clearing the parameter buffer at packet start leaves unused bytes zero on accept.
      if (clr_pkt) begin
        sum  <= '0;
        pbuf <= '0;
      end
      if (add_sum) sum <= sum + bus.rx_data;
      if (st_id)   id_q <= bus.rx_data;
      if (st_len)  len_q <= bus.rx_data;
      if (st_err) begin
        err_q <= bus.rx_data;
        cnt   <= '0;
      end
      if (st_param) begin
        for (int k = 0; k < MAX_PARAMS; k++)
          if (cnt == 4'(k)) pbuf[k*8 +: 8] <= bus.rx_data;
        cnt <= cnt + 4'd1;
      end
      if (go_pkt) begin
        bus.pkt_id      <= id_q;
        bus.pkt_error   <= err_q;
        bus.pkt_nparams <= len_q[3:0] - 4'd2;
        bus.pkt_params  <= pbuf;
      end
    end
  end
endmodule

// File: tb/tb_dynamixel_status_parser.sv
// Scoreboard bench for the Dynamixel status parser: the stimulus queues expected pulses
// with their cycle and packet fields, and a negedge monitor pops and compares them.
module tb_dynamixel_status_parser;
  localparam int MP  = 4;
  localparam int TMO = 20;

  localparam int K_PKT = 0;
  localparam int K_CHK = 1;
  localparam int K_LEN = 2;
  localparam int K_ID  = 3;
  localparam int K_TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dynamixel_status_parser_if #(.MAX_PARAMS(MP)) bus();

  dynamixel_status_parser #(.MAX_PARAMS(MP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] id;
    logic [7:0] err;
    logic [3:0] np;
    logic [31:0] par;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  txq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_edge = 0;
  int          s_edge;
  logic [7:0]  m_id, m_err;
  logic [3:0]  m_np;
  logic [31:0] m_par;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_model(input logic [7:0] id, input logic [7:0] err,
                           input logic [3:0] np, input logic [31:0] par);
    m_id = id; m_err = err; m_np = np; m_par = par;
  endtask

  task automatic expect_ev(input int kind, input int at);
    exp_t e;
    e.kind = kind; e.cyc = at;
    e.id = m_id; e.err = m_err; e.np = m_np; e.par = m_par;
    q.push_back(e);
  endtask

  // Called on a negedge; the byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b, input int kind);
    last_edge = cyc + 1;
    if (kind >= 0) expect_ev(kind, last_edge);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_q(input int kind);
    for (int i = 0; i < txq.size(); i++)
      send_byte(txq[i], (i == txq.size() - 1) ? kind : -1);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  int   n_p, act_kind;
  exp_t me;
  always @(negedge clk) begin
    if (!reset) begin
      n_p = int'(bus.pkt_valid) + int'(bus.chk_err) + int'(bus.len_err)
          + int'(bus.id_err) + int'(bus.timeout_err);
      if (n_p > 0) begin
        check("one_pulse", n_p, 1);
        act_kind = bus.pkt_valid ? K_PKT : bus.chk_err ? K_CHK : bus.len_err ? K_LEN :
                   bus.id_err ? K_ID : K_TMO;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected none", act_kind, cyc);
        end else begin
          me = q.pop_front();
          check("pulse_kind", act_kind, me.kind);
          check("pulse_cycle", cyc, me.cyc);
          check("pkt_id", bus.pkt_id, me.id);
          check("pkt_error", bus.pkt_error, me.err);
          check("pkt_nparams", bus.pkt_nparams, me.np);
          check("pkt_params", bus.pkt_params, me.par);
        end
      end
    end
  end

  initial begin
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.expected_id = 8'h01;
    set_model(8'h00, 8'h00, 4'd0, 32'h0);
    gap(3);
    check("rst_busy", bus.busy, 0);
    check("rst_pkt_valid", bus.pkt_valid, 0);
    check("rst_errs", {bus.chk_err, bus.len_err, bus.id_err, bus.timeout_err}, 0);
    check("rst_pkt_id", bus.pkt_id, 0);
    check("rst_pkt_error", bus.pkt_error, 0);
    check("rst_pkt_nparams", bus.pkt_nparams, 0);
    check("rst_pkt_params", bus.pkt_params, 0);
    reset = 1'b0;
    gap(1);

    // Two-parameter good packet.
    set_model(8'h01, 8'h00, 4'd2, 32'h0000_0120);
    txq = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h01, 8'hD9};
    send_q(K_PKT); gap(2);

    // Same packet with a bad checksum: outputs must hold.
    txq = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h01, 8'hD8};
    send_q(K_CHK); gap(2);

    // Broadcast accept, back-to-back packets (next header lands in the pulse cycle).
    bus.expected_id = 8'hFE;
    set_model(8'h03, 8'h00, 4'd1, 32'h0000_00AA);
    txq = '{8'hFF, 8'hFF, 8'h03, 8'h03, 8'h00, 8'hAA, 8'h4F};
    send_q(K_PKT);
    set_model(8'h02, 8'h04, 4'd4, 32'h4030_2010);
    txq = '{8'hFF, 8'hFF, 8'h02, 8'h06, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h53};
    send_q(K_PKT); gap(2);

    // Length out of range, above and below.
    bus.expected_id = 8'h01;
    txq = '{8'hFF, 8'hFF, 8'h01, 8'h07};
    send_q(K_LEN); gap(2);
    txq = '{8'hFF, 8'hFF, 8'h01, 8'h01};
    send_q(K_LEN); gap(2);

    // Zero-parameter packet with an extra sync byte; unused params zeroed.
    set_model(8'h01, 8'h00, 4'd0, 32'h0);
    txq = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
    send_q(K_PKT); gap(2);

    // Wrong ID, then wrong ID plus bad checksum (checksum wins).
    bus.expected_id = 8'h05;
    send_q(K_ID); gap(2);
    txq = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h01, 8'hD8};
    send_q(K_CHK); gap(2);

    // Broken header returns to idle silently, then a good packet.
    bus.expected_id = 8'hFE;
    txq = '{8'h12, 8'hFF, 8'h00};
    send_q(-1);
    set_model(8'h03, 8'h00, 4'd1, 32'h0000_00AA);
    txq = '{8'hFF, 8'hFF, 8'h03, 8'h03, 8'h00, 8'hAA, 8'h4F};
    send_q(K_PKT); gap(2);

    // Silence after LEN: timeout TMO-1 clocks after the LEN strobe.
    bus.expected_id = 8'h01;
    txq = '{8'hFF, 8'hFF, 8'h01, 8'h04};
    send_q(-1);
    expect_ev(K_TMO, last_edge + TMO - 1);
    gap(TMO + 5);

    // A byte on exactly the timeout cycle wins and the packet completes.
    txq = '{8'hFF, 8'hFF, 8'h01, 8'h04};
    send_q(-1);
    s_edge = last_edge;
    for (int k = 0; k < TMO && cyc < s_edge + TMO - 2; k++) @(negedge clk);
    set_model(8'h01, 8'h00, 4'd2, 32'h0000_0120);
    txq = '{8'h00, 8'h20, 8'h01, 8'hD9};
    send_q(K_PKT); gap(TMO + 5);

    // Reset mid-packet abandons it silently; the next packet parses normally.
    txq = '{8'hFF, 8'hFF, 8'h01};
    send_q(-1);
    check("busy_mid_packet", bus.busy, 1);
    reset = 1'b1;
    gap(1);
    check("reset_busy", bus.busy, 0);
    check("reset_pkt_id", bus.pkt_id, 0);
    check("reset_pkt_nparams", bus.pkt_nparams, 0);
    check("reset_pkt_params", bus.pkt_params, 0);
    set_model(8'h00, 8'h00, 4'd0, 32'h0);
    reset = 1'b0;
    gap(1);
    set_model(8'h01, 8'h00, 4'd2, 32'h0000_0120);
    txq = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h01, 8'hD9};
    send_q(K_PKT); gap(5);

    check("events_outstanding", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dynamixel_status_parser.md
DYNAMIXEL_STATUS_PARSER -- requirements
Module: dynamixel_status_parser

Interface
REQ-001 The block SHALL have parameter MAX_PARAMS, default 4, the maximum number of status parameter bytes accepted.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, the inter-byte timeout in clk cycles (1 ms at 50 MHz).
REQ-003 Port clk  input  1  system clock; all state on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-006 Port rx_data  input  8  received byte from the Dynamixel UART receiver.
REQ-007 Port expected_id  input  8  servo ID the parser accepts; 0xFE accepts any ID.
REQ-008 Port pkt_valid  output  1  one-cycle pulse: a good status packet has been latched.
REQ-009 Port pkt_id  output  8  ID of the last good packet.
REQ-010 Port pkt_error  output  8  error byte of the last good packet.
REQ-011 Port pkt_nparams  output  4  parameter count of the last good packet.
REQ-012 Port pkt_params  output  8*MAX_PARAMS  parameters; param k at bits [8k+7:8k].
REQ-013 Port chk_err, len_err, id_err, timeout_err  output  1 each  one-cycle error pulses.
REQ-014 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Status packet format SHALL be Protocol 1.0: FF FF ID LEN ERR P0..P(N-1) CHK, with LEN = N+2 and CHK = ~(ID+LEN+ERR+sum P) mod 256.
REQ-016 The FSM SHALL have states IDLE, HDR2, ID, LEN, ERR, PARAM and CHK, and SHALL advance only on cycles where rx_valid=1.
REQ-017 IDLE: byte 0xFF -> HDR2; any other byte is ignored.
REQ-018 HDR2: byte 0xFF -> ID; any other byte -> IDLE, with no error pulse.
REQ-019 ID: byte 0xFF -> stay in ID (extra sync bytes are tolerated); any other byte is stored as the ID -> LEN.
REQ-020 LEN: a value in 2..MAX_PARAMS+2 is stored -> ERR; any other value pulses len_err -> IDLE.
REQ-021 ERR: the byte is stored; go to CHK if LEN=2, else to PARAM.
REQ-022 PARAM: each byte is stored at index cnt and cnt increments; after byte LEN-3 -> CHK.
REQ-023 The running sum SHALL be 8 bits wide, wrapping modulo 256, cleared on entry to ID, and SHALL accumulate ID, LEN, ERR and all params.
REQ-024 CHK, match with ID accepted -> all pkt_* outputs updated, unused pkt_params bytes zeroed, pkt_valid pulsed; then IDLE.
REQ-025 CHK mismatch -> chk_err pulse, pkt_* outputs unchanged -> IDLE; a checksum error takes priority over an ID mismatch.
REQ-026 CHK match with ID != expected_id and expected_id != 0xFE -> id_err pulse, pkt_* outputs unchanged -> IDLE.
REQ-027 Latency: pkt_valid and all error pulses SHALL be asserted on the cycle immediately after the rx_valid cycle of the deciding byte.
REQ-028 Timeout counter: cleared on every rx_valid and held at 0 in IDLE; when it reaches TIMEOUT_CYCLES-1 outside IDLE -> timeout_err pulse -> IDLE.
REQ-029 When rx_valid and the timeout condition coincide, the byte SHALL win: it is processed, the counter is cleared, and no timeout_err is pulsed.
REQ-030 At most one of pkt_valid, chk_err, len_err, id_err and timeout_err SHALL be high in any cycle.
REQ-031 A byte arriving in the cycle a pulse is asserted SHALL be processed from IDLE, so no bytes are lost.

Reset
REQ-032 While reset=1: FSM=IDLE, counters and sum=0, all pulses=0, busy=0, and pkt_id, pkt_error, pkt_nparams, pkt_params=0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet without any pulse; the next packet after release SHALL parse normally.

Verification
REQ-034 expected_id=01, bytes FF FF 01 04 00 20 01 D9 -> pkt_valid one cycle after D9; pkt_id=01, pkt_error=00, pkt_nparams=2, pkt_params=0x00000120.
REQ-035 Same packet with CHK=D8 -> chk_err only; pkt_* outputs keep their previous values.
REQ-036 FF FF 01 07 ... (LEN=7 > 6) -> len_err on the cycle after the 07 byte, then IDLE.
REQ-037 FF FF FF 01 02 00 FC -> pkt_valid, pkt_nparams=0, pkt_params=0; with expected_id=05 instead -> id_err only.
REQ-038 FF FF 01 04 followed by silence -> timeout_err exactly TIMEOUT_CYCLES-1 cycles after the 04 strobe, with a byte in that same cycle -> no timeout_err.
REQ-039 reset pulsed after FF FF 01 -> busy=0 with no pulses; a subsequent full good packet -> pkt_valid.
